// File: rtl/maze_two_game.sv
// Level-two maze game state: player tile, revealed-tile map, in-order checkpoints, flash/seconds counter.
// Moves land 3 cycles after the synchronised button edge; no backpressure, requests outside IDLE are dropped.
module maze_two_game #(
  parameter logic [197:0] WALLS       = {18'h0, {9{18'h1FFFE}}, 18'h0},
  parameter int unsigned  START_IDX   = 19,
  parameter int unsigned  CP0         = 31,
  parameter int unsigned  CP1         = 37,
  parameter int unsigned  CP2         = 113,
  parameter int unsigned  CP3         = 139,
  parameter int unsigned  CP4         = 178,
  parameter int unsigned  FLASH_TICKS = 500,
  parameter int unsigned  SEC_TICKS   = 1000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         tick,
  input  logic         btn_u,
  input  logic         btn_d,
  input  logic         btn_l,
  input  logic         btn_r,
  input  logic         restart,
  output logic [197:0] mazestate,
  output logic [7:0]   counter,
  output logic [7:0]   player_idx,
  output logic [2:0]   cp_count,
  output logic         done
);

  localparam int unsigned FW = $clog2(FLASH_TICKS + 1);
  localparam int unsigned PW = $clog2(SEC_TICKS);

  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_MOVE, ST_FLASH, ST_WIN} state_t;

  localparam logic [1:0] DIR_U = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_R = 2'd3;

  // Tile itself plus each in-bounds neighbour that is a path tile; rows never wrap.
  function automatic logic [197:0] reveal(input logic [7:0] idx);
    logic [197:0] m;
    logic [7:0]   row;
    logic [7:0]   col;
    m   = '0;
    row = idx / 8'd18;
    col = idx % 8'd18;
    m[idx] = 1'b1;
    if (row != 8'd0  && WALLS[idx - 8'd18]) m[idx - 8'd18] = 1'b1;
    if (row != 8'd10 && WALLS[idx + 8'd18]) m[idx + 8'd18] = 1'b1;
    if (col != 8'd0  && WALLS[idx - 8'd1])  m[idx - 8'd1]  = 1'b1;
    if (col != 8'd17 && WALLS[idx + 8'd1])  m[idx + 8'd1]  = 1'b1;
    return m;
  endfunction

  localparam logic [197:0] INIT_MAP = reveal(8'(START_IDX));

  logic [4:0]    sync1_q, sync2_q, prev_q;
  logic [4:0]    btn_edge;
  logic [3:0]    dir_edge;
  logic          move_req;
  state_t        state_q, state_d;
  logic [7:0]    player_idx_q, player_idx_d;
  logic [7:0]    target_q, target_d;
  logic [1:0]    dir_q, dir_d;
  logic [197:0]  mazestate_q, mazestate_d;
  logic [2:0]    cp_count_q, cp_count_d;
  logic [7:0]    elapsed_q, elapsed_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic [7:0]    cur_row, cur_col, cp_tile;
  logic          blocked;

  assign btn_edge = sync2_q & ~prev_q;
  assign dir_edge = btn_edge[3:0];
  assign move_req = (dir_edge != 4'd0) && ((dir_edge & (dir_edge - 4'd1)) == 4'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {restart, btn_r, btn_l, btn_d, btn_u};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    cur_row = player_idx_q / 8'd18;
    cur_col = player_idx_q % 8'd18;
    blocked = ((dir_q == DIR_U) && (cur_row == 8'd0))  ||
              ((dir_q == DIR_D) && (cur_row == 8'd10)) ||
              ((dir_q == DIR_L) && (cur_col == 8'd0))  ||
              ((dir_q == DIR_R) && (cur_col == 8'd17)) ||
              (target_q >= 8'd198) || !WALLS[target_q];
    case (cp_count_q)
      3'd0:    cp_tile = 8'(CP0);
      3'd1:    cp_tile = 8'(CP1);
      3'd2:    cp_tile = 8'(CP2);
      3'd3:    cp_tile = 8'(CP3);
      3'd4:    cp_tile = 8'(CP4);
      default: cp_tile = 8'hFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    player_idx_d = player_idx_q;
    target_d     = target_q;
    dir_d        = dir_q;
    mazestate_d  = mazestate_q;
    cp_count_d   = cp_count_q;
    elapsed_d    = elapsed_q;
    presc_d      = presc_q;
    flash_cnt_d  = flash_cnt_q;

    // Seconds keep running through CHECK/MOVE/FLASH; 255 stays reserved for the flash.
    if (tick && state_q != ST_WIN) begin
      if (presc_q == PW'(SEC_TICKS - 1)) begin
        presc_d = '0;
        if (elapsed_q != 8'd254) elapsed_d = elapsed_q + 8'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (move_req) begin
          state_d = ST_CHECK;
          if (dir_edge[0]) begin
            dir_d = DIR_U; target_d = player_idx_q - 8'd18;
          end else if (dir_edge[1]) begin
            dir_d = DIR_D; target_d = player_idx_q + 8'd18;
          end else if (dir_edge[2]) begin
            dir_d = DIR_L; target_d = player_idx_q - 8'd1;
          end else begin
            dir_d = DIR_R; target_d = player_idx_q + 8'd1;
          end
        end
      end
      ST_CHECK: begin
        if (blocked) begin
          state_d     = ST_FLASH;
          flash_cnt_d = FW'(FLASH_TICKS);
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        player_idx_d = target_q;
        mazestate_d  = mazestate_q | reveal(target_q);
        state_d      = ST_IDLE;
        if (target_q == cp_tile) begin
          cp_count_d = cp_count_q + 3'd1;
          if (cp_count_q == 3'd4) state_d = ST_WIN;
        end
      end
      ST_FLASH: begin
        if (tick) begin
          flash_cnt_d = flash_cnt_q - FW'(1);
          if (flash_cnt_q == FW'(1)) state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (btn_edge[4]) begin
      state_d      = ST_IDLE;
      player_idx_d = 8'(START_IDX);
      target_d     = '0;
      dir_d        = DIR_U;
      mazestate_d  = INIT_MAP;
      cp_count_d   = '0;
      elapsed_d    = '0;
      presc_d      = '0;
      flash_cnt_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      player_idx_q <= 8'(START_IDX);
      target_q     <= '0;
      dir_q        <= DIR_U;
      mazestate_q  <= INIT_MAP;
      cp_count_q   <= '0;
      elapsed_q    <= '0;
      presc_q      <= '0;
      flash_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      player_idx_q <= player_idx_d;
      target_q     <= target_d;
      dir_q        <= dir_d;
      mazestate_q  <= mazestate_d;
      cp_count_q   <= cp_count_d;
      elapsed_q    <= elapsed_d;
      presc_q      <= presc_d;
      flash_cnt_q  <= flash_cnt_d;
    end
  end

  assign mazestate  = mazestate_q;
  assign player_idx = player_idx_q;
  assign cp_count   = cp_count_q;
  assign done       = (state_q == ST_WIN);
  assign counter    = (state_q == ST_FLASH) ? 8'd255 : elapsed_q;

endmodule

// File: tb/tb_maze_two_game.sv
// Directed bench for maze_two_game: main instance (seconds prescaler shortened to 20 ticks) plus an open-map instance starting at tile 35.
module tb_maze_two_game;

  logic         CLK, RST_N, tick, btn_u, btn_d, btn_l, btn_r, restart;
  logic [197:0] mazestate;
  logic [7:0]   counter, player_idx;
  logic [2:0]   cp_count;
  logic         done;

  logic         tick_b, btn_u_b, btn_d_b, btn_l_b, btn_r_b, restart_b;
  logic [197:0] mazestate_b;
  logic [7:0]   counter_b, player_idx_b;
  logic [2:0]   cp_count_b;
  logic         done_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [197:0] exp_init, exp_map, exp_b;

  maze_two_game #(.SEC_TICKS(20)) dut (
    .CLK(CLK), .RST_N(RST_N), .tick(tick),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .restart(restart),
    .mazestate(mazestate), .counter(counter), .player_idx(player_idx),
    .cp_count(cp_count), .done(done)
  );

  maze_two_game #(.START_IDX(35), .WALLS({198{1'b1}})) dut_b (
    .CLK(CLK), .RST_N(RST_N), .tick(tick_b),
    .btn_u(btn_u_b), .btn_d(btn_d_b), .btn_l(btn_l_b), .btn_r(btn_r_b), .restart(restart_b),
    .mazestate(mazestate_b), .counter(counter_b), .player_idx(player_idx_b),
    .cp_count(cp_count_b), .done(done_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [197:0] got, input logic [197:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mask = {restart, r, l, d, u}
  task automatic press(input logic [4:0] mask);
    @(negedge CLK);
    {restart, btn_r, btn_l, btn_d, btn_u} = mask;
    repeat (6) @(negedge CLK);
    {restart, btn_r, btn_l, btn_d, btn_u} = 5'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    @(negedge CLK);
    tick = 1'b1;
    repeat (n) @(negedge CLK);
    tick = 1'b0;
  endtask

  task automatic walk(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "U":     press(5'b00001);
        "D":     press(5'b00010);
        "L":     press(5'b00100);
        default: press(5'b01000);
      endcase
    end
  endtask

  task automatic check_init(input string tag);
    check({tag, "_player"}, 198'(player_idx), 198'd19);
    check({tag, "_map"},    mazestate, exp_init);
    check({tag, "_counter"}, 198'(counter), 198'd0);
    check({tag, "_cp"},     198'(cp_count), 198'd0);
    check({tag, "_done"},   198'(done), 198'd0);
  endtask

  initial begin
    RST_N = 1'b0; tick = 1'b0;
    {restart, btn_r, btn_l, btn_d, btn_u} = 5'b0;
    tick_b = 1'b0;
    {restart_b, btn_r_b, btn_l_b, btn_d_b, btn_u_b} = 5'b0;
    exp_init = '0;
    exp_init[19] = 1'b1; exp_init[20] = 1'b1; exp_init[37] = 1'b1;
    exp_b = '0;
    exp_b[17] = 1'b1; exp_b[34] = 1'b1; exp_b[35] = 1'b1; exp_b[53] = 1'b1;

    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset state
    check_init("reset");
    check("b_reset_player", 198'(player_idx_b), 198'd35);
    check("b_reset_map", mazestate_b, exp_b);

    // Right edge of row 1 must not wrap onto tile 36
    @(negedge CLK); btn_r_b = 1'b1;
    repeat (6) @(negedge CLK); btn_r_b = 1'b0;
    repeat (2) @(negedge CLK);
    check("b_edge_flash", 198'(counter_b), 198'd255);
    check("b_edge_player", 198'(player_idx_b), 198'd35);
    check("b_edge_map", mazestate_b, exp_b);

    // Wall hit left of 19, flash lasts exactly 500 ticks
    press(5'b00100);
    check("flash_on", 198'(counter), 198'd255);
    check("flash_player", 198'(player_idx), 198'd19);
    press(5'b00010);
    check("flash_drop_down", 198'(player_idx), 198'd19);
    ticks(499);
    check("flash_499", 198'(counter), 198'd255);
    ticks(1);
    check("flash_end_elapsed", 198'(counter), 198'd25);
    press(5'b00010);
    exp_map = exp_init;
    exp_map[38] = 1'b1; exp_map[55] = 1'b1;
    check("move_down_player", 198'(player_idx), 198'd37);
    check("move_down_map", mazestate, exp_map);
    check("move_down_cp", 198'(cp_count), 198'd0);

    // Simultaneous left+right edges are dropped
    press(5'b01100);
    check("dual_player", 198'(player_idx), 198'd37);
    check("dual_counter", 198'(counter), 198'd25);
    check("dual_map", mazestate, exp_map);

    press(5'b10000);
    check_init("restart1");

    // Checkpoint walk
    walk("RRRRRRRRRRRR");
    check("cp1_player", 198'(player_idx), 198'd31);
    check("cp1_count", 198'(cp_count), 198'd1);
    walk("LLLLLLLLLLLLD");
    check("cp2_player", 198'(player_idx), 198'd37);
    check("cp2_count", 198'(cp_count), 198'd2);
    walk("DDDDRRRR");
    check("cp3_player", 198'(player_idx), 198'd113);
    check("cp3_count", 198'(cp_count), 198'd3);
    ticks(30);
    check("elapsed_1", 198'(counter), 198'd1);
    walk("DRRRRRRRR");
    check("cp4_player", 198'(player_idx), 198'd139);
    check("cp4_count", 198'(cp_count), 198'd4);
    check("cp4_not_done", 198'(done), 198'd0);
    walk("DDRRR");
    check("cp5_player", 198'(player_idx), 198'd178);
    check("cp5_count", 198'(cp_count), 198'd5);
    check("cp5_done", 198'(done), 198'd1);
    check("win_map_178", 198'(mazestate[178]), 198'd1);
    check("win_map_179", 198'(mazestate[179]), 198'd0);
    ticks(40);
    check("win_elapsed_frozen", 198'(counter), 198'd1);
    press(5'b00100);
    check("win_no_move", 198'(player_idx), 198'd178);
    press(5'b10000);
    check_init("restart2");

    // Seconds saturate at 254
    ticks(5100);
    check("elapsed_sat", 198'(counter), 198'd254);
    ticks(40);
    check("elapsed_sat_hold", 198'(counter), 198'd254);

    // Asynchronous reset in the middle of a flash
    press(5'b00100);
    check("flash2_on", 198'(counter), 198'd255);
    ticks(10);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_init("async_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_init("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
